layer4_fc2: RTL and testbench

Final fully-connected stage of the MNIST pipeline: FC2, 32 → 10. Consumes the 32 serial int8 activations produced by the FC1 stage and computes 10 int32 logits with a single time-multiplexed MAC, reading weights directly from ROM with no preload. Streams the logits out serially. Optionally reports the arg-max class index for the board-level result logic.

---
 rtl/layer4_fc2.sv | 180 ++++++++++++++++++
 tb/tb_layer4_fc2.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer4_fc2.sv
// FC2 32->10: one time-multiplexed int8 MAC over ROM weights, int32 logits streamed serially.
// Build option FC2_ARGMAX_EN adds the arg-max comparator driving pred_class/pred_valid.

module rom_FC2_WEIGHTS #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 320
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) q <= mem[addr];
endmodule

module rom_FC2_BIASES_INT32 #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) q <= mem[addr];
endmodule

module layer4_fc2 #(
  parameter int             IN_LEN     = 32,
  parameter int             OUT_LEN    = 10,
  parameter logic [8*64-1:0] W_MEM_FILE = "rtl/weights/FC2_WEIGHTS.mem",
  parameter logic [8*64-1:0] B_MEM_FILE = "rtl/weights/FC2_BIASES_INT32.mem"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] in_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic [3:0]  pred_class,
  output logic        pred_valid,
  output logic        busy
);
  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  localparam logic [4:0] LAST_IN  = 5'(IN_LEN - 1);
  localparam logic [3:0] LAST_OC  = 4'(OUT_LEN - 1);
  localparam logic [3:0] OUT_DONE = 4'(OUT_LEN);

  state_t             state;
  logic [4:0]         in_idx;
  logic [3:0]         oc;
  logic [5:0]         sc;
  logic [3:0]         out_idx;
  logic signed [31:0] acc;
  logic [7:0]         w_q;
  logic [31:0]        b_q;
  logic [8:0]         w_addr;
  logic [4:0]         fidx;
  logic signed [15:0] prod;
  logic signed [7:0]  feature_buf [IN_LEN];
  logic signed [31:0] logit [OUT_LEN];

  // ROM file names are consumed by the ROM image flow; the upper input byte lanes carry nothing.
  logic unused_bits;
  assign unused_bits = ^{in_data[31:8], W_MEM_FILE, B_MEM_FILE};

  assign w_addr = {oc, sc[4:0]};
  assign fidx   = sc[4:0] - 5'd1;
  assign prod   = feature_buf[fidx] * $signed(w_q);
  assign busy   = (state != S_LOAD);

  rom_FC2_WEIGHTS #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .DEPTH(320)) u_w_rom (
    .clk  (clk),
    .addr (w_addr),
    .q    (w_q)
  );

  rom_FC2_BIASES_INT32 #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(10)) u_b_rom (
    .clk  (clk),
    .addr (oc),
    .q    (b_q)
  );

  // Slot cycle sc: weight for k issued at sc=k, arrives at sc=k+1 alongside feature k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      in_idx    <= 5'd0;
      oc        <= 4'd0;
      sc        <= 6'd0;
      out_idx   <= 4'd0;
      acc       <= 32'sd0;
      out_data  <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_LOAD: begin
          if (valid_in) begin
            if (in_idx == LAST_IN) begin
              in_idx <= 5'd0;
              oc     <= 4'd0;
              sc     <= 6'd0;
              state  <= S_COMPUTE;
            end else begin
              in_idx <= in_idx + 5'd1;
            end
          end
        end
        S_COMPUTE: begin
          if (sc == 6'd0) acc <= 32'sd0;
          else if (sc <= 6'd32) acc <= acc + {{16{prod[15]}}, prod};
          if (sc == 6'd33) begin
            sc <= 6'd0;
            if (oc == LAST_OC) begin
              oc      <= 4'd0;
              out_idx <= 4'd0;
              state   <= S_OUTPUT;
            end else begin
              oc <= oc + 4'd1;
            end
          end else begin
            sc <= sc + 6'd1;
          end
        end
        S_OUTPUT: begin
          // Extra cycle after the last logit keeps busy high while out_valid is still up.
          if (out_idx == OUT_DONE) begin
            state <= S_LOAD;
          end else begin
            out_data  <= logit[out_idx];
            out_valid <= 1'b1;
            out_idx   <= out_idx + 4'd1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD && valid_in) feature_buf[in_idx] <= in_data[7:0];
    if (state == S_COMPUTE && sc == 6'd33) logit[oc] <= acc + b_q;
  end

`ifdef FC2_ARGMAX_EN
  logic signed [31:0] best_val;
  logic [3:0]         best_idx;

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_val   <= 32'sd0;
      best_idx   <= 4'd0;
      pred_class <= 4'd0;
      pred_valid <= 1'b0;
    end else begin
      pred_valid <= 1'b0;
      if (state == S_OUTPUT) begin
        if (out_idx == OUT_DONE) begin
          pred_class <= best_idx;
          pred_valid <= 1'b1;
        end else if (out_idx == 4'd0 || logit[out_idx] > best_val) begin
          best_val <= logit[out_idx];
          best_idx <= out_idx;
        end
      end
    end
  end
`else
  assign pred_class = 4'd0;
  assign pred_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer4_fc2.sv
// Scoreboard bench for layer4_fc2: random and directed frames against a plain-arithmetic FC model.
module tb_layer4_fc2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic [3:0]  pred_class;
  logic        pred_valid;
  logic        busy;

  layer4_fc2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .pred_class (pred_class),
    .pred_valid (pred_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_seen = 0;
  int   cyc = 0;
  int   wm[320];
  int   bm[10];
  int   xv[32];
  int   exp_lg[10];
  int   exp_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every logit on the output must match the head of the scoreboard, in value and cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: out_data 0x%08h with empty scoreboard (cycle %0d)", out_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("logit", out_data, mon_e.val);
        check("out_cycle", cyc, mon_e.cyc);
        check("busy_during_out", 32'(busy), 32'd1);
      end
    end
  end

  // Reference: logit = bias + dot(x, weight row), int32 wrap; arg-max with lowest index on ties.
  function automatic void compute_model();
    for (int oc = 0; oc < 10; oc++) begin
      int s;
      s = bm[oc];
      for (int i = 0; i < 32; i++) s += xv[i] * wm[oc * 32 + i];
      exp_lg[oc] = s;
    end
    exp_pc = 0;
    for (int oc = 1; oc < 10; oc++) if (exp_lg[oc] > exp_lg[exp_pc]) exp_pc = oc;
  endfunction

  task automatic setup_rom();
    for (int i = 0; i < 320; i++) dut.u_w_rom.mem[i] = wm[i][7:0];
    for (int i = 0; i < 10; i++) dut.u_b_rom.mem[i] = bm[i];
  endtask

  task automatic drive_inputs(input int n, input logic [23:0] hi, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      valid_in = 1'b1;
      in_data  = {hi, xv[i][7:0]};
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic start_frame(input logic [23:0] hi, input bit gaps);
    int   c;
    exp_t e;
    compute_model();
    drive_inputs(32, hi, gaps);
    c = cyc;
    for (int j = 0; j < 10; j++) begin
      e.val = exp_lg[j];
      e.cyc = c + 341 + j;
      exp_q.push_back(e);
    end
    check("busy_after_load", 32'(busy), 32'd1);
  endtask

  task automatic finish_frame(input int n_drop, input int seen0);
    int t;
    for (int d = 0; d < n_drop; d++) begin
      repeat ($urandom_range(5, 50)) begin @(posedge clk); #1; end
      valid_in = 1'b1;
      in_data  = $urandom();
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
    t = 0;
    while (n_seen < seen0 + 10 && t < 800) begin
      @(posedge clk);
      t++;
    end
    if (n_seen < seen0 + 10) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: saw %0d logits, expected %0d", n_seen - seen0, 10);
    end
    #1;
    check("busy_after_out", 32'(busy), 32'd0);
`ifdef FC2_ARGMAX_EN
    check("pred_valid", 32'(pred_valid), 32'd1);
    check("pred_class", 32'(pred_class), 32'(exp_pc));
`else
    check("pred_valid_off", 32'(pred_valid), 32'd0);
    check("pred_class_off", 32'(pred_class), 32'd0);
`endif
  endtask

  task automatic run_frame(input logic [23:0] hi, input bit gaps, input int n_drop);
    int seen0;
    seen0 = n_seen;
    start_frame(hi, gaps);
    finish_frame(n_drop, seen0);
  endtask

  task automatic reset_check(input string tag);
    valid_in = 1'b0;
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_pred_class"}, 32'(pred_class), 32'd0);
    check({tag, "_pred_valid"}, 32'(pred_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 320; i++) wm[i] = i / 32;
    for (int i = 0; i < 10; i++) bm[i] = 0;
    for (int i = 0; i < 32; i++) xv[i] = 1;
    setup_rom();
  endtask

  task automatic set_random();
    for (int i = 0; i < 320; i++) wm[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < 10; i++) bm[i] = int'($urandom());
    for (int i = 0; i < 32; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
    setup_rom();
  endtask

  initial begin
    int seen0;
    int t;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pred_class", 32'(pred_class), 32'd0);
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_ramp();
    run_frame(24'h0, 1'b0, 0);

    for (int i = 0; i < 320; i++) wm[i] = -128;
    for (int i = 0; i < 10; i++) bm[i] = -1;
    for (int i = 0; i < 32; i++) xv[i] = -128;
    setup_rom();
    run_frame(24'h000000, 1'b1, 0);
    run_frame(24'hFFFFFF, 1'b1, 0);

    for (int i = 0; i < 320; i++) wm[i] = 0;
    bm[0] = -5; bm[1] = 3; bm[2] = 3; bm[3] = -7;
    for (int i = 4; i < 10; i++) bm[i] = -10 - i;
    setup_rom();
    run_frame(24'($urandom()), 1'b0, 0);
    for (int i = 0; i < 10; i++) bm[i] = 77;
    setup_rom();
    run_frame(24'($urandom()), 1'b1, 0);

    set_random();
    run_frame(24'($urandom()), 1'b1, 5);
    set_random();
    run_frame(24'($urandom()), 1'b0, 0);
    set_random();
    run_frame(24'($urandom()), 1'b1, 0);

    // Reset while logits are streaming: remaining logits must never appear.
    seen0 = n_seen;
    start_frame(24'h0, 1'b0);
    t = 0;
    while (n_seen < seen0 + 3 && t < 800) begin
      @(posedge clk);
      t++;
    end
    reset_check("rst_mid_out");
    repeat (400) @(posedge clk);
    #1;
    run_frame(24'h0, 1'b0, 0);

    // Reset part way through loading, then a clean ramp frame.
    set_ramp();
    for (int i = 0; i < 32; i++) xv[i] = 5;
    drive_inputs(17, 24'h0, 1'b0);
    reset_check("rst_mid_load");
    for (int i = 0; i < 32; i++) xv[i] = 1;
    run_frame(24'h0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
